ctrl_unit: RTL



---
 rtl/ctrl_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 16-bit lab CPU.
// Latches the instruction word during FETCH. Drives the program counter
// controls, the register-file write enables and the ALU controls from the
// current state and the latched instruction register.
module ctrl_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ins,
  input  logic        zero,
  output logic        pc_en,
  output logic [1:0]  pc_ctrl,
  output logic [7:0]  offset_addr,
  output logic [15:0] ir_out,
  output logic [2:0]  rs_sel,
  output logic [2:0]  rt_sel,
  output logic [7:0]  reg_en,
  output logic [3:0]  alu_func,
  output logic        alu_in_sel,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_LOAD = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_JUMP = 5'b00110;
  localparam logic [4:0] OP_BZ   = 5'b00111;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;

  state_t      state;
  state_t      next_state;
  logic [15:0] ir;
  logic [4:0]  opcode;
  logic        writes_reg;

  assign opcode      = ir[15:11];
  assign ir_out      = ir;
  assign rs_sel      = ir[7:5];
  assign rt_sel      = ir[4:2];
  assign offset_addr = ir[7:0];
  assign writes_reg  = (opcode == OP_LOAD) || (opcode == OP_ADD) ||
                       (opcode == OP_SUB)  || (opcode == OP_AND) ||
                       (opcode == OP_OR);

  // State register; reset aborts any instruction in flight and returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Instruction register captures the ROM word on the edge that ends FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir <= 16'h0000;
    end else if (state == S_FETCH) begin
      ir <= ins;
    end
  end

  // Next-state logic: fixed four-cycle loop; HALT is left only through reset.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = start ? S_FETCH : S_IDLE;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC:   next_state = (opcode == OP_HALT) ? S_HALT : S_WB;
      S_WB:     next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_IDLE;
    endcase
  end

  // Output decode: PC, ALU and register-file controls from state and ir.
  always_comb begin
    pc_en      = 1'b0;
    pc_ctrl    = PC_HOLD;
    reg_en     = 8'h00;
    alu_func   = 4'b0000;
    alu_in_sel = 1'b0;
    halted     = (state == S_HALT);

    if (state == S_FETCH) begin
      pc_en   = 1'b1;
      pc_ctrl = PC_INC;
    end

    if (state == S_EXEC) begin
      if ((opcode == OP_JUMP) || ((opcode == OP_BZ) && zero)) begin
        pc_en   = 1'b1;
        pc_ctrl = PC_LOAD;
      end
    end

    if ((state == S_EXEC) || (state == S_WB)) begin
      case (opcode)
        OP_LOAD: begin
          alu_func   = 4'b0000;
          alu_in_sel = 1'b1;
        end
        OP_ADD:  alu_func = 4'b0001;
        OP_SUB:  alu_func = 4'b0010;
        OP_AND:  alu_func = 4'b0011;
        OP_OR:   alu_func = 4'b0100;
        OP_NOP:  alu_func = 4'b0000;
        default: alu_func = 4'b0000;
      endcase
    end

    if ((state == S_WB) && writes_reg) begin
      reg_en = 8'd1 << ir[10:8];
    end
  end

endmodule
